poly_arbiter: RTL and testbench

POLY_ARBITER -- requirements
Module: poly_arbiter

---
 rtl/poly_arbiter_pkg.sv | 78 +++++++
 rtl/poly_arbiter_bo.sv | 73 +++++++
 rtl/poly_arbiter.sv | 139 +++++++++++++
 tb/tb_poly_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/poly_arbiter_pkg.sv
// Shared types for the two-client polynomial arbiter: sequencer states,
// datapath select codes, operand bundle and per-state control decode.
package poly_arbiter_pkg;

   localparam int unsigned X_W   = 8;
   localparam int unsigned D_W   = 16;
   localparam int unsigned SEL_W = 2;

   typedef enum logic [3:0] {
      IDLE = 4'd0,
      LOAD = 4'd1,
      SQ   = 4'd2,
      AXX  = 4'd3,
      BX   = 4'd4,
      ADD1 = 4'd5,
      ADD2 = 4'd6,
      CAPT = 4'd7,
      RESP = 4'd8
   } state_e;

   // M0 coefficient mux
   localparam logic [SEL_W-1:0] M0_A = 2'd0;
   localparam logic [SEL_W-1:0] M0_B = 2'd2;
   localparam logic [SEL_W-1:0] M0_C = 2'd3;

   // M1/M2 operand selects
   localparam logic [SEL_W-1:0] M_MUX0 = 2'd0;
   localparam logic [SEL_W-1:0] M_X    = 2'd1;
   localparam logic [SEL_W-1:0] M_S    = 2'd2;
   localparam logic [SEL_W-1:0] M_H    = 2'd3;

   localparam logic H_MUL = 1'b1;
   localparam logic H_ADD = 1'b0;

   typedef struct packed {
      logic [X_W-1:0] x;
      logic [D_W-1:0] a;
      logic [D_W-1:0] b;
      logic [D_W-1:0] c;
   } operand_t;

   typedef struct packed {
      logic             lx;
      logic             h;
      logic             ls;
      logic             lh;
      logic [SEL_W-1:0] m0;
      logic [SEL_W-1:0] m1;
      logic [SEL_W-1:0] m2;
   } dp_ctrl_t;

   // Datapath control word presented while the sequencer sits in st.
   function automatic dp_ctrl_t ctrl_for(input state_e st);
      dp_ctrl_t c;
      c = '0;
      case (st)
         LOAD: c.lx = 1'b1;
         SQ: begin
            c.m1 = M_X;   c.m2 = M_MUX0; c.h = H_MUL; c.ls = 1'b1;
         end
         AXX: begin
            c.m0 = M0_A;  c.m1 = M_MUX0; c.m2 = M_S;  c.h = H_MUL; c.lh = 1'b1;
         end
         BX: begin
            c.m0 = M0_B;  c.m1 = M_MUX0; c.m2 = M_MUX0; c.h = H_MUL; c.ls = 1'b1;
         end
         ADD1: begin
            c.m1 = M_S;   c.m2 = M_H;    c.h = H_ADD; c.lh = 1'b1;
         end
         ADD2: begin
            c.m0 = M0_C;  c.m1 = M_MUX0; c.m2 = M_H;  c.h = H_ADD; c.ls = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/poly_arbiter_bo.sv
// Polynomial datapath: x latch, S and H accumulators and one mul/add unit,
// steered entirely by the sequencer's control word.
module poly_arbiter_bo
   import poly_arbiter_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic             dp_LX,
   input  logic             dp_H,
   input  logic             dp_LS,
   input  logic             dp_LH,
   input  logic [1:0]       dp_M0,
   input  logic [1:0]       dp_M1,
   input  logic [1:0]       dp_M2,
   input  logic [7:0]       dp_x,
   input  logic [15:0]      dp_a,
   input  logic [15:0]      dp_b,
   input  logic [15:0]      dp_c,
   output logic [15:0]      dp_resultado
);

   logic [X_W-1:0] x_q, x_d;
   logic [D_W-1:0] s_q, s_d;
   logic [D_W-1:0] h_q, h_d;
   logic [D_W-1:0] mux0, op1, op2, alu;

   // Second operand port has no coefficient path; its low codes pick x.
   always_comb begin
      mux0 = '0;
      case (dp_M0)
         M0_A:    mux0 = dp_a;
         M0_B:    mux0 = dp_b;
         M0_C:    mux0 = dp_c;
         default: mux0 = '0;
      endcase

      op1 = mux0;
      case (dp_M1)
         M_MUX0:  op1 = mux0;
         M_X:     op1 = D_W'(x_q);
         M_S:     op1 = s_q;
         default: op1 = h_q;
      endcase

      op2 = D_W'(x_q);
      case (dp_M2)
         M_S:     op2 = s_q;
         M_H:     op2 = h_q;
         default: op2 = D_W'(x_q);
      endcase

      alu = (dp_H == H_MUL) ? D_W'(op1 * op2) : D_W'(op1 + op2);

      x_d = dp_LX ? dp_x : x_q;
      s_d = dp_LS ? alu  : s_q;
      h_d = dp_LH ? alu  : h_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         x_q <= '0;
         s_q <= '0;
         h_q <= '0;
      end else begin
         x_q <= x_d;
         s_q <= s_d;
         h_q <= h_d;
      end
   end

   assign dp_resultado = s_q;

endmodule

// File: rtl/poly_arbiter.sv
// Round-robin arbiter and sequencer for a shared a*x*x + b*x + c datapath;
// the datapath itself lives outside this module.
module poly_arbiter
   import poly_arbiter_pkg::*;
#(
   parameter int unsigned RR_INIT = 0
)(
   input  logic        clock,
   input  logic        reset,
   input  logic        req0,
   input  logic        req1,
   input  logic [7:0]  x0,
   input  logic [7:0]  x1,
   input  logic [15:0] a0,
   input  logic [15:0] a1,
   input  logic [15:0] b0,
   input  logic [15:0] b1,
   input  logic [15:0] c0,
   input  logic [15:0] c1,
   output logic        gnt0,
   output logic        gnt1,
   output logic        done0,
   output logic        done1,
   output logic [15:0] result,
   output logic        busy,
   output logic        dp_LX,
   output logic        dp_H,
   output logic        dp_LS,
   output logic        dp_LH,
   output logic [1:0]  dp_M0,
   output logic [1:0]  dp_M1,
   output logic [1:0]  dp_M2,
   output logic [7:0]  dp_x,
   output logic [15:0] dp_a,
   output logic [15:0] dp_b,
   output logic [15:0] dp_c,
   input  logic [15:0] dp_resultado
);

   state_e         state_q, state_d;
   logic           prio_q, prio_d;
   logic           win_q, win_d;
   operand_t       ops_q, ops_d;
   logic [D_W-1:0] result_q, result_d;
   dp_ctrl_t       ctrl_q, ctrl_d;
   logic           gnt0_q, gnt0_d, gnt1_q, gnt1_d;
   logic           done0_q, done0_d, done1_q, done1_d;
   logic           busy_q, busy_d;

   // Next state; outputs are decoded from the next state so they register
   // in step with state_q.
   always_comb begin
      state_d  = state_q;
      prio_d   = prio_q;
      win_d    = win_q;
      ops_d    = ops_q;
      result_d = result_q;

      case (state_q)
         IDLE: begin
            if (req0 || req1) begin
               win_d = (req0 && req1) ? prio_q : req1;
               if (win_d) ops_d = '{x: x1, a: a1, b: b1, c: c1};
               else       ops_d = '{x: x0, a: a0, b: b0, c: c0};
               state_d = LOAD;
            end
         end
         LOAD: state_d = SQ;
         SQ:   state_d = AXX;
         AXX:  state_d = BX;
         BX:   state_d = ADD1;
         ADD1: state_d = ADD2;
         ADD2: state_d = CAPT;
         CAPT: begin
            result_d = dp_resultado;
            state_d  = RESP;
         end
         RESP: begin
            prio_d  = ~win_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      gnt0_d  = (state_d == LOAD) && !win_d;
      gnt1_d  = (state_d == LOAD) &&  win_d;
      done0_d = (state_d == RESP) && !win_d;
      done1_d = (state_d == RESP) &&  win_d;
      busy_d  = (state_d != IDLE);
      ctrl_d  = ctrl_for(state_d);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= IDLE;
         prio_q   <= 1'(RR_INIT);
         win_q    <= 1'b0;
         ops_q    <= '0;
         result_q <= '0;
         ctrl_q   <= '0;
         gnt0_q   <= 1'b0;
         gnt1_q   <= 1'b0;
         done0_q  <= 1'b0;
         done1_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         prio_q   <= prio_d;
         win_q    <= win_d;
         ops_q    <= ops_d;
         result_q <= result_d;
         ctrl_q   <= ctrl_d;
         gnt0_q   <= gnt0_d;
         gnt1_q   <= gnt1_d;
         done0_q  <= done0_d;
         done1_q  <= done1_d;
         busy_q   <= busy_d;
      end
   end

   assign gnt0   = gnt0_q;
   assign gnt1   = gnt1_q;
   assign done0  = done0_q;
   assign done1  = done1_q;
   assign busy   = busy_q;
   assign result = result_q;
   assign dp_LX  = ctrl_q.lx;
   assign dp_H   = ctrl_q.h;
   assign dp_LS  = ctrl_q.ls;
   assign dp_LH  = ctrl_q.lh;
   assign dp_M0  = ctrl_q.m0;
   assign dp_M1  = ctrl_q.m1;
   assign dp_M2  = ctrl_q.m2;
   assign dp_x   = ops_q.x;
   assign dp_a   = ops_q.a;
   assign dp_b   = ops_q.b;
   assign dp_c   = ops_q.c;

endmodule

// File: tb/tb_poly_arbiter.sv
// Bench for poly_arbiter wired to its datapath: table of single services
// plus hand sequences for control decode, back-to-back, reset abort, fairness.
module tb_poly_arbiter;

   logic        clock = 1'b0;
   logic        reset, req0, req1;
   logic [7:0]  x0, x1;
   logic [15:0] a0, b0, c0, a1, b1, c1;
   logic        gnt0, gnt1, done0, done1, busy;
   logic [15:0] result;
   logic        dp_LX, dp_H, dp_LS, dp_LH;
   logic [1:0]  dp_M0, dp_M1, dp_M2;
   logic [7:0]  dp_x;
   logic [15:0] dp_a, dp_b, dp_c, dp_resultado;

   always #5 clock = ~clock;

   poly_arbiter dut (
      .clock(clock), .reset(reset), .req0(req0), .req1(req1),
      .x0(x0), .x1(x1), .a0(a0), .a1(a1), .b0(b0), .b1(b1), .c0(c0), .c1(c1),
      .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
      .result(result), .busy(busy),
      .dp_LX(dp_LX), .dp_H(dp_H), .dp_LS(dp_LS), .dp_LH(dp_LH),
      .dp_M0(dp_M0), .dp_M1(dp_M1), .dp_M2(dp_M2),
      .dp_x(dp_x), .dp_a(dp_a), .dp_b(dp_b), .dp_c(dp_c),
      .dp_resultado(dp_resultado)
   );

   poly_arbiter_bo u_bo (
      .clock(clock), .reset(reset),
      .dp_LX(dp_LX), .dp_H(dp_H), .dp_LS(dp_LS), .dp_LH(dp_LH),
      .dp_M0(dp_M0), .dp_M1(dp_M1), .dp_M2(dp_M2),
      .dp_x(dp_x), .dp_a(dp_a), .dp_b(dp_b), .dp_c(dp_c),
      .dp_resultado(dp_resultado)
   );

   typedef struct {
      logic        r0, r1;
      logic [7:0]  vx0, vx1;
      logic [15:0] va0, vb0, vc0, va1, vb1, vc1;
      logic        exp_cl;
      logic [15:0] exp_res;
   } vec_t;

   vec_t       vt [7];
   logic [9:0] exp_ctrl [8];
   logic [9:0] ctrl;
   int         n_checks = 0;
   int         n_errors = 0;

   assign ctrl = {dp_LX, dp_H, dp_LS, dp_LH, dp_M0, dp_M1, dp_M2};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic set_ops(input logic [7:0] ix0, input logic [15:0] ia0, ib0, ic0,
                          input logic [7:0] ix1, input logic [15:0] ia1, ib1, ic1);
      x0 = ix0; a0 = ia0; b0 = ib0; c0 = ic0;
      x1 = ix1; a1 = ia1; b1 = ib1; c1 = ic1;
   endtask

   task automatic wait_gnt(input string name);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (!(gnt0 || gnt1) && n < 30);
      chk({name, "_gnt_wait"}, 32'(gnt0 || gnt1), 32'd1);
   endtask

   task automatic wait_done(input string name, output int lat);
      lat = 0;
      do begin
         tick();
         lat++;
      end while (!(done0 || done1) && lat < 30);
      chk({name, "_done_wait"}, 32'(done0 || done1), 32'd1);
   endtask

   initial begin
      int lat, n;
      logic prio_m, exp_w;
      logic pat [6];

      vt[0] = '{1'b1, 1'b0,   8'd3,   8'd0,   16'd2,   16'd5, 16'd7,     16'd0, 16'd0, 16'd0, 1'b0, 16'd40};
      vt[1] = '{1'b0, 1'b1,   8'd0,   8'd10,  16'd0,   16'd0, 16'd0,     16'd1, 16'd0, 16'd1, 1'b1, 16'd101};
      vt[2] = '{1'b1, 1'b0,   8'd255, 8'd0,   16'd2,   16'd0, 16'd0,     16'd0, 16'd0, 16'd0, 1'b0, 16'hFC02};
      vt[3] = '{1'b1, 1'b1,   8'd9,   8'd4,   16'd1,   16'd1, 16'd1,     16'd3, 16'd2, 16'd1, 1'b1, 16'd57};
      vt[4] = '{1'b1, 1'b1,   8'd0,   8'd7,   16'd9,   16'd9, 16'd65535, 16'd5, 16'd5, 16'd5, 1'b0, 16'd65535};
      vt[5] = '{1'b1, 1'b0,   8'd16,  8'd0,   16'd256, 16'd1, 16'd0,     16'd0, 16'd0, 16'd0, 1'b0, 16'd16};
      vt[6] = '{1'b1, 1'b1,   8'd1,   8'd200, 16'd1,   16'd1, 16'd1,     16'd1, 16'd1, 16'd1, 1'b1, 16'd40201};

      exp_ctrl[0] = 10'b1_0_0_0_00_00_00;  // LOAD
      exp_ctrl[1] = 10'b0_1_1_0_00_01_00;  // SQ
      exp_ctrl[2] = 10'b0_1_0_1_00_00_10;  // AXX
      exp_ctrl[3] = 10'b0_1_1_0_10_00_00;  // BX
      exp_ctrl[4] = 10'b0_0_0_1_00_10_11;  // ADD1
      exp_ctrl[5] = 10'b0_0_1_0_11_00_11;  // ADD2
      exp_ctrl[6] = 10'b0;                 // CAPT
      exp_ctrl[7] = 10'b0;                 // RESP

      req0 = 1'b0; req1 = 1'b0;
      set_ops(8'd0, 16'd0, 16'd0, 16'd0, 8'd0, 16'd0, 16'd0, 16'd0);
      do_reset();

      // Reset state
      chk("rst_flags",  32'({gnt0, gnt1, done0, done1, busy}), 32'd0);
      chk("rst_ctrl",   32'(ctrl), 32'd0);
      chk("rst_result", 32'(result), 32'd0);
      chk("rst_ops",    32'({dp_x, dp_a} | {8'd0, dp_b} | {8'd0, dp_c}), 32'd0);

      // Per-state control decode on a lone client-0 service
      set_ops(8'd3, 16'd2, 16'd5, 16'd7, 8'd0, 16'd0, 16'd0, 16'd0);
      req0 = 1'b1;
      wait_gnt("seq_a");
      req0 = 1'b0;
      for (int s = 0; s < 8; s++) begin
         if (s > 0) tick();
         chk($sformatf("ctrl_st%0d", s), 32'(ctrl), 32'(exp_ctrl[s]));
         chk($sformatf("busy_st%0d", s), 32'(busy), 32'd1);
         chk($sformatf("done_st%0d", s), 32'({done1, done0}), (s == 7) ? 32'd1 : 32'd0);
      end
      chk("seq_a_result", 32'(result), 32'd40);
      tick();
      chk("seq_a_idle", 32'(busy), 32'd0);

      // Table of single services; operands scrambled after grant
      do_reset();
      for (int i = 0; i < 7; i++) begin
         set_ops(vt[i].vx0, vt[i].va0, vt[i].vb0, vt[i].vc0,
                 vt[i].vx1, vt[i].va1, vt[i].vb1, vt[i].vc1);
         req0 = vt[i].r0;
         req1 = vt[i].r1;
         wait_gnt($sformatf("v%0d", i));
         chk($sformatf("v%0d_gnt", i), 32'({gnt1, gnt0}), vt[i].exp_cl ? 32'd2 : 32'd1);
         chk($sformatf("v%0d_dp_x", i), 32'(dp_x), vt[i].exp_cl ? 32'(vt[i].vx1) : 32'(vt[i].vx0));
         chk($sformatf("v%0d_dp_c", i), 32'(dp_c), vt[i].exp_cl ? 32'(vt[i].vc1) : 32'(vt[i].vc0));
         req0 = 1'b0; req1 = 1'b0;
         set_ops(8'hA5, 16'h1234, 16'h5678, 16'h9ABC, 8'h5A, 16'h4321, 16'h8765, 16'hCBA9);
         wait_done($sformatf("v%0d", i), lat);
         chk($sformatf("v%0d_lat", i), 32'(lat), 32'd7);
         chk($sformatf("v%0d_done", i), 32'({done1, done0}), vt[i].exp_cl ? 32'd2 : 32'd1);
         chk($sformatf("v%0d_result", i), 32'(result), 32'(vt[i].exp_res));
         tick();
         chk($sformatf("v%0d_hold", i), 32'({busy, result}), 32'(vt[i].exp_res));
      end

      // Both requesting through reset: client 0 first, client 1 two cycles later
      set_ops(8'd3, 16'd2, 16'd5, 16'd7, 8'd10, 16'd1, 16'd0, 16'd1);
      req0 = 1'b1; req1 = 1'b1;
      do_reset();
      wait_gnt("b2b_0");
      chk("b2b_gnt0", 32'({gnt1, gnt0}), 32'd1);
      wait_done("b2b_0", lat);
      chk("b2b_lat0", 32'(lat), 32'd7);
      chk("b2b_res0", 32'(result), 32'd40);
      n = 0;
      do begin
         tick();
         n++;
      end while (!(gnt0 || gnt1) && n < 10);
      chk("b2b_gap", 32'(n), 32'd2);
      chk("b2b_gnt1", 32'({gnt1, gnt0}), 32'd2);
      req0 = 1'b0; req1 = 1'b0;
      wait_done("b2b_1", lat);
      chk("b2b_done1", 32'({done1, done0}), 32'd2);
      chk("b2b_res1", 32'(result), 32'd101);

      // Reset in AXX aborts; held req0 is re-granted right after release
      set_ops(8'd3, 16'd2, 16'd5, 16'd7, 8'd0, 16'd0, 16'd0, 16'd0);
      req0 = 1'b1;
      wait_gnt("abort");
      tick();
      tick();
      chk("abort_in_axx", 32'(ctrl), 32'(exp_ctrl[2]));
      reset = 1'b1;
      tick();
      chk("abort_flags", 32'({gnt0, gnt1, done0, done1, busy}), 32'd0);
      chk("abort_ctrl", 32'(ctrl), 32'd0);
      chk("abort_ops", 32'({dp_x, dp_a} | {8'd0, dp_c}), 32'd0);
      chk("abort_result", 32'(result), 32'd0);
      reset = 1'b0;
      tick();
      chk("abort_regnt", 32'({gnt1, gnt0}), 32'd1);
      req0 = 1'b0;
      wait_done("abort", lat);
      chk("abort_lat", 32'(lat), 32'd7);
      chk("abort_res", 32'(result), 32'd40);

      // Fairness: req1 held, req0 toggled between services
      pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      req0 = 1'b0; req1 = 1'b0;
      set_ops(8'd3, 16'd2, 16'd5, 16'd7, 8'd10, 16'd1, 16'd0, 16'd1);
      do_reset();
      prio_m = 1'b0;
      req1 = 1'b1;
      for (int i = 0; i < 6; i++) begin
         req0 = pat[i];
         exp_w = pat[i] ? prio_m : 1'b1;
         wait_gnt($sformatf("rr%0d", i));
         chk($sformatf("rr%0d_gnt", i), 32'({gnt1, gnt0}), exp_w ? 32'd2 : 32'd1);
         prio_m = ~exp_w;
         wait_done($sformatf("rr%0d", i), lat);
         chk($sformatf("rr%0d_res", i), 32'(result), exp_w ? 32'd101 : 32'd40);
      end
      req0 = 1'b0; req1 = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
